// File: rtl/moonbase_nibble_bus.sv
// moonbase_nibble_bus: nibble-serial memory/bus sequencer.
// Takes one word-wide read/write request and either runs it on the 4-bit
// external pins (address strobe, optional wait states, MS-nibble-first
// transfer) or services it from on-die local RAM in a single cycle.
// Optional build macro MOONBASE_NIBBLE_BUS_READY_EN adds the pad_rdy input,
// which lets the external device stretch each nibble transfer.
module moonbase_nibble_bus #(
  parameter int DATA_W      = 8,   // word width, multiple of 4, 4..16
  parameter int ADDR_W      = 7,   // external address width
  parameter int N_LOCAL     = 8,   // local RAM depth, power of 2, >= 2
  parameter int WAIT_STATES = 0    // idle cycles between strobe and first nibble
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             req_valid,
  output logic                             req_ready,
  input  logic                             req_write,
  input  logic                             req_code,
  input  logic                             req_local,
  input  logic [ADDR_W-1:0]                req_addr,
  input  logic [DATA_W-1:0]                req_wdata,
  output logic                             rsp_valid,
  output logic [DATA_W-1:0]                rsp_rdata,
  output logic                             busy,
  input  logic [3:0]                       pad_in,
`ifdef MOONBASE_NIBBLE_BUS_READY_EN
  input  logic                             pad_rdy,
`endif
  output logic                             pad_strobe,
  output logic [ADDR_W-1:0]                pad_aout,
  output logic [3:0]                       pad_dout,
  output logic                             pad_we_n,
  output logic                             pad_code,
  output logic [$clog2(DATA_W/4):0]        pad_nib
);

  localparam int NIB   = DATA_W / 4;
  localparam int NIB_W = $clog2(NIB) + 1;
  localparam int LOC_W = $clog2(N_LOCAL);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_WAIT,
    ST_XFER,
    ST_LOCAL,
    ST_DONE
  } state_t;

  state_t state, state_next;

  // Request fields captured on acceptance and held for the whole access.
  logic              write_q;
  logic              code_q;
  logic              local_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;

  // Transfer bookkeeping.
  logic [3:0]        wait_q;
  logic [NIB_W-1:0]  idx_q;
  logic [DATA_W-1:0] data_q;     // read assembly register
  logic [DATA_W-1:0] rd_merge;   // data_q with the nibble on pad_in inserted
  logic              nib_go;     // current nibble completes this cycle
  logic [LOC_W-1:0]  local_idx;

  // Local RAM; wraps on the low address bits.
  logic [DATA_W-1:0] mem [N_LOCAL];

`ifdef MOONBASE_NIBBLE_BUS_READY_EN
  assign nib_go = pad_rdy;
`else
  assign nib_go = 1'b1;
`endif

  assign local_idx = addr_q[LOC_W-1:0];

  // Insert the incoming nibble at the current index of the read register.
  always_comb begin
    rd_merge = data_q;
    rd_merge[int'(idx_q)*4 +: 4] = pad_in;
  end

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values, independent of block evaluation order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode.
  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE: begin
        if (req_valid) begin
          state_next = req_local ? ST_LOCAL : ST_ADDR;
        end
      end
      ST_ADDR: begin
        state_next = (WAIT_STATES > 0) ? ST_WAIT : ST_XFER;
      end
      ST_WAIT: begin
        if (wait_q <= 4'd1) begin
          state_next = ST_XFER;
        end
      end
      ST_XFER: begin
        if (nib_go && (idx_q == '0)) begin
          state_next = ST_DONE;
        end
      end
      ST_LOCAL: state_next = ST_DONE;
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Pin and response outputs, decoded from state so reset clears them at once.
  // NOTE: every output gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    pad_strobe = 1'b0;
    pad_aout   = '0;
    pad_code   = 1'b0;
    pad_dout   = 4'h0;
    pad_we_n   = 1'b1;
    pad_nib    = '0;
    rsp_valid  = 1'b0;
    busy       = (state != ST_IDLE);
    unique case (state)
      ST_ADDR: begin
        pad_strobe = 1'b1;
        pad_aout   = addr_q;
        pad_code   = code_q;
      end
      ST_WAIT: begin
        pad_aout = addr_q;
        pad_code = code_q;
      end
      ST_XFER: begin
        pad_aout = addr_q;
        pad_code = code_q;
        pad_nib  = idx_q;
        if (write_q) begin
          pad_we_n = 1'b0;
          pad_dout = wdata_q[int'(idx_q)*4 +: 4];
        end
      end
      ST_DONE: begin
        rsp_valid = 1'b1;
        if (!local_q) begin
          pad_aout = addr_q;
          pad_code = code_q;
        end
      end
      default: ;
    endcase
  end

  // Ready is gated by reset directly so it reads 0 for the whole reset pulse.
  assign req_ready = reset_n && (state == ST_IDLE);

  // Request capture, wait counting, nibble assembly and read response.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      write_q   <= 1'b0;
      code_q    <= 1'b0;
      local_q   <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wait_q    <= 4'd0;
      idx_q     <= '0;
      data_q    <= '0;
      rsp_rdata <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (req_valid) begin
            write_q <= req_write;
            code_q  <= req_code;
            local_q <= req_local;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
          end
        end
        ST_ADDR: begin
          wait_q <= 4'(WAIT_STATES);
          idx_q  <= NIB_W'(NIB - 1);
        end
        ST_WAIT: begin
          wait_q <= wait_q - 4'd1;
        end
        ST_XFER: begin
          if (nib_go) begin
            if (!write_q) begin
              data_q <= rd_merge;
              // Last nibble: publish the word so it is valid alongside rsp_valid.
              if (idx_q == '0) begin
                rsp_rdata <= rd_merge;
              end
            end
            if (idx_q != '0) begin
              idx_q <= idx_q - NIB_W'(1);
            end
          end
        end
        ST_LOCAL: begin
          if (!write_q) begin
            rsp_rdata <= mem[local_idx];
          end
        end
        default: ;
      endcase
    end
  end

  // Local RAM write port.
  // NOTE: the RAM array is deliberately not reset; clearing it would force
  // flops instead of a RAM macro and software never relies on its contents.
  always_ff @(posedge clk) begin
    if ((state == ST_LOCAL) && write_q) begin
      mem[local_idx] <= wdata_q;
    end
  end

endmodule

// File: tb/tb_moonbase_nibble_bus.sv
// Self-checking bench for moonbase_nibble_bus.
// Two instances: A (DATA_W=8, WAIT_STATES=0) and B (DATA_W=16, WAIT_STATES=2).
// Expected responses are queued when a request is driven and compared when
// the DUT pulses rsp_valid; pin timing is checked cycle by cycle.
module tb_moonbase_nibble_bus;

  typedef struct {
    int idx;
    bit rdy;
  } slot_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid_a = 1'b0;
  logic        req_valid_b = 1'b0;
  logic        req_write = 1'b0;
  logic        req_code = 1'b0;
  logic        req_local = 1'b0;
  logic [6:0]  req_addr = '0;
  logic [15:0] req_wdata = '0;
  logic [3:0]  pad_in = 4'h0;
  logic        pad_rdy = 1'b1;

  // Instance A outputs
  logic        req_ready_a, rsp_valid_a, busy_a, pad_strobe_a, pad_we_n_a, pad_code_a;
  logic [7:0]  rsp_rdata_a;
  logic [6:0]  pad_aout_a;
  logic [3:0]  pad_dout_a;
  logic [1:0]  pad_nib_a;
  // Instance B outputs
  logic        req_ready_b, rsp_valid_b, busy_b, pad_strobe_b, pad_we_n_b, pad_code_b;
  logic [15:0] rsp_rdata_b;
  logic [6:0]  pad_aout_b;
  logic [3:0]  pad_dout_b;
  logic [2:0]  pad_nib_b;

  // Selected-instance view used by the pin-level checks
  bit          sel_b = 1'b0;
  logic        m_ready, m_rsp_valid, m_busy, m_strobe, m_we_n, m_code;
  logic [6:0]  m_aout;
  logic [3:0]  m_dout;
  logic [2:0]  m_nib;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [15:0] q_a[$];
  logic [15:0] q_b[$];
  logic [15:0] last_rd [2];
  logic [7:0]  lmem [8];

  always #5 clk = ~clk;

  moonbase_nibble_bus #(.DATA_W(8), .ADDR_W(7), .N_LOCAL(8), .WAIT_STATES(0)) dut_a (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid_a), .req_ready(req_ready_a),
    .req_write(req_write), .req_code(req_code), .req_local(req_local),
    .req_addr(req_addr), .req_wdata(req_wdata[7:0]),
    .rsp_valid(rsp_valid_a), .rsp_rdata(rsp_rdata_a), .busy(busy_a),
    .pad_in(pad_in),
`ifdef MOONBASE_NIBBLE_BUS_READY_EN
    .pad_rdy(pad_rdy),
`endif
    .pad_strobe(pad_strobe_a), .pad_aout(pad_aout_a), .pad_dout(pad_dout_a),
    .pad_we_n(pad_we_n_a), .pad_code(pad_code_a), .pad_nib(pad_nib_a)
  );

  moonbase_nibble_bus #(.DATA_W(16), .ADDR_W(7), .N_LOCAL(8), .WAIT_STATES(2)) dut_b (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid_b), .req_ready(req_ready_b),
    .req_write(req_write), .req_code(req_code), .req_local(req_local),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid_b), .rsp_rdata(rsp_rdata_b), .busy(busy_b),
    .pad_in(pad_in),
`ifdef MOONBASE_NIBBLE_BUS_READY_EN
    .pad_rdy(1'b1),
`endif
    .pad_strobe(pad_strobe_b), .pad_aout(pad_aout_b), .pad_dout(pad_dout_b),
    .pad_we_n(pad_we_n_b), .pad_code(pad_code_b), .pad_nib(pad_nib_b)
  );

  always_comb begin
    if (sel_b) begin
      m_ready = req_ready_b; m_rsp_valid = rsp_valid_b; m_busy = busy_b;
      m_strobe = pad_strobe_b; m_we_n = pad_we_n_b; m_code = pad_code_b;
      m_aout = pad_aout_b; m_dout = pad_dout_b; m_nib = pad_nib_b;
    end else begin
      m_ready = req_ready_a; m_rsp_valid = rsp_valid_a; m_busy = busy_a;
      m_strobe = pad_strobe_a; m_we_n = pad_we_n_a; m_code = pad_code_a;
      m_aout = pad_aout_a; m_dout = pad_dout_a; m_nib = {1'b0, pad_nib_a};
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard consumers: one per instance.
  always @(negedge clk) begin
    if (reset_n && rsp_valid_a === 1'b1) begin
      check("rsp_pending_a", 32'(q_a.size() != 0), 1);
      if (q_a.size() != 0) check("rdata_a", rsp_rdata_a, q_a.pop_front());
    end
  end

  always @(negedge clk) begin
    if (reset_n && rsp_valid_b === 1'b1) begin
      check("rsp_pending_b", 32'(q_b.size() != 0), 1);
      if (q_b.size() != 0) check("rdata_b", rsp_rdata_b, q_b.pop_front());
    end
  end

  // External access on instance sel. For reads, data is what the external
  // RAM returns; for writes, the word to be written. stall = pad_rdy-low
  // cycles on nibble 1; hold keeps req_valid high until the DONE cycle.
  task automatic ext_req(input bit sel, input bit wr, input bit code,
                         input logic [6:0] addr, input logic [15:0] data,
                         input int stall, input bit hold);
    slot_t sched[$];
    slot_t s;
    int nib, ws, xs, done;
    logic [3:0] nibble;
    nib = sel ? 4 : 2;
    ws  = sel ? 2 : 0;
    xs  = 2 + ws;
    for (int j = 0; j < nib; j++) begin
      int idx = nib - 1 - j;
      int reps = (idx == 1) ? stall + 1 : 1;
      for (int r = 0; r < reps; r++) sched.push_back('{idx, r == reps - 1});
    end
    done = xs + sched.size();

    @(negedge clk);
    sel_b = sel;
    #1;
    check("ready_idle", m_ready, 1);
    req_write = wr; req_code = code; req_local = 1'b0; req_addr = addr; req_wdata = data;
    if (sel) req_valid_b = 1'b1; else req_valid_a = 1'b1;
    if (!wr) last_rd[sel] = data;
    if (sel) q_b.push_back(last_rd[sel]); else q_a.push_back(last_rd[sel]);
    @(posedge clk);
    #1;
    if (!hold) begin req_valid_a = 1'b0; req_valid_b = 1'b0; end

    for (int k = 1; k <= done + 2; k++) begin
      @(negedge clk);
      pad_rdy = 1'b1;
      pad_in  = 4'h0;
      if (hold && k == done) begin req_valid_a = 1'b0; req_valid_b = 1'b0; end
      #1;
      check("strobe", m_strobe, 32'(k == 1));
      check("aout", m_aout, (k <= done) ? 32'(addr) : 32'd0);
      check("code", m_code, (k <= done) ? 32'(code) : 32'd0);
      check("rsp_valid", m_rsp_valid, 32'(k == done));
      check("busy", m_busy, 32'(k <= done));
      if (k >= xs && k < done) begin
        s = sched[k - xs];
        nibble = data[s.idx*4 +: 4];
        check("nib", m_nib, s.idx);
        pad_rdy = s.rdy;
        if (wr) begin
          check("we_n_xfer", m_we_n, 0);
          check("dout_xfer", m_dout, nibble);
        end else begin
          check("we_n_rd", m_we_n, 1);
          check("dout_rd", m_dout, 0);
          pad_in = s.rdy ? nibble : ~nibble;
        end
      end else begin
        check("we_n_idle", m_we_n, 1);
        check("dout_idle", m_dout, 0);
      end
    end
  endtask

  // Local RAM access on instance A (responds at T+2, no pin activity).
  task automatic loc_req(input bit wr, input logic [6:0] addr, input logic [7:0] data);
    @(negedge clk);
    sel_b = 1'b0;
    #1;
    check("ready_loc", m_ready, 1);
    req_write = wr; req_code = 1'b0; req_local = 1'b1; req_addr = addr; req_wdata = {8'h00, data};
    req_valid_a = 1'b1;
    if (wr) lmem[addr[2:0]] = data;
    else last_rd[0] = {8'h00, lmem[addr[2:0]]};
    q_a.push_back(last_rd[0]);
    @(posedge clk);
    #1;
    req_valid_a = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      #1;
      check("loc_strobe", m_strobe, 0);
      check("loc_we_n", m_we_n, 1);
      check("loc_rsp_valid", m_rsp_valid, 32'(k == 2));
      check("loc_busy", m_busy, 32'(k <= 2));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    last_rd[0] = '0;
    last_rd[1] = '0;
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_ready", req_ready_a, 0);
    check("rst_busy", busy_a, 0);
    check("rst_strobe", pad_strobe_a, 0);
    check("rst_we_n", pad_we_n_a, 1);
    check("rst_aout", pad_aout_a, 0);
    check("rst_dout", pad_dout_a, 0);
    check("rst_code", pad_code_a, 0);
    check("rst_nib", pad_nib_a, 0);
    check("rst_rsp_valid", rsp_valid_a, 0);
    check("rst_rdata_a", rsp_rdata_a, 0);
    check("rst_rdata_b", rsp_rdata_b, 0);
    reset_n = 1'b1;
    #1;
    check("rel_ready_a", req_ready_a, 1);
    check("rel_ready_b", req_ready_b, 1);

    // Instance A: 8-bit, zero wait
    ext_req(1'b0, 1'b0, 1'b0, 7'h15, 16'h00A3, 0, 1'b0);
    ext_req(1'b0, 1'b1, 1'b1, 7'h7F, 16'h005C, 0, 1'b0);
    ext_req(1'b0, 1'b0, 1'b1, 7'h00, 16'h006E, 0, 1'b0);
    ext_req(1'b0, 1'b1, 1'b0, 7'h2B, 16'h00F1, 0, 1'b0);

    // Instance B: 16-bit, two wait states
    ext_req(1'b1, 1'b0, 1'b0, 7'h2A, 16'h1234, 0, 1'b0);
    ext_req(1'b1, 1'b1, 1'b1, 7'h11, 16'hBEEF, 0, 1'b0);
    ext_req(1'b1, 1'b0, 1'b1, 7'h7F, 16'hFFFF, 0, 1'b0);

    // Local RAM with address wrap
    loc_req(1'b1, 7'h09, 8'h99);
    loc_req(1'b0, 7'h01, 8'h00);
    loc_req(1'b1, 7'h02, 8'h42);
    loc_req(1'b0, 7'h0A, 8'h00);
    loc_req(1'b0, 7'h79, 8'h00);

    // req_valid held through a whole access: must be taken once only
    ext_req(1'b0, 1'b0, 1'b0, 7'h33, 16'h00C7, 0, 1'b1);

`ifdef MOONBASE_NIBBLE_BUS_READY_EN
    ext_req(1'b0, 1'b0, 1'b0, 7'h44, 16'h005A, 3, 1'b0);
    ext_req(1'b0, 1'b1, 1'b1, 7'h45, 16'h00D2, 2, 1'b0);
    ext_req(1'b1, 1'b0, 1'b0, 7'h46, 16'h9876, 0, 1'b0);
`endif

    // Reset in the middle of a write transfer
    @(negedge clk);
    sel_b = 1'b0;
    req_write = 1'b1; req_code = 1'b0; req_local = 1'b0; req_addr = 7'h12; req_wdata = 16'h0077;
    req_valid_a = 1'b1;
    @(posedge clk);
    #1;
    req_valid_a = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("abort_we_n_before", pad_we_n_a, 0);
    reset_n = 1'b0;
    #1;
    check("abort_we_n", pad_we_n_a, 1);
    check("abort_busy", busy_a, 0);
    check("abort_ready_in_rst", req_ready_a, 0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("abort_ready_rel", req_ready_a, 1);
    last_rd[0] = '0;
    last_rd[1] = '0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      #1;
      check("abort_no_rsp", rsp_valid_a, 0);
    end

    // Recovery access after the abort
    ext_req(1'b0, 1'b0, 1'b1, 7'h5D, 16'h0081, 0, 1'b0);

    repeat (2) @(negedge clk);
    check("sb_empty_a", q_a.size(), 0);
    check("sb_empty_b", q_b.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
